// File: rtl/i2c_slave_regs_if.sv
// rtl/i2c_slave_regs_if.sv - I2C slave register file bus: PHY byte handshake and local host port
interface i2c_slave_regs_if #(
   parameter int PW = 4
);
   logic          start;
   logic          stop;
   logic [7:0]    datareceive;
   logic          received;
   logic [7:0]    datasend;
   logic          sended;
   logic [PW-1:0] host_addr;
   logic [7:0]    host_wdata;
   logic          host_we;
   logic [7:0]    host_rdata;
   logic          wr_pulse;
   logic [PW-1:0] wr_addr;
   logic [PW-1:0] ptr;

   modport slave (
      input  start, stop, datareceive, received, sended, host_addr, host_wdata, host_we,
      output datasend, host_rdata, wr_pulse, wr_addr, ptr
   );

   modport master (
      output start, stop, datareceive, received, sended, host_addr, host_wdata, host_we,
      input  datasend, host_rdata, wr_pulse, wr_addr, ptr
   );
endinterface

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C slave register file with auto-incrementing pointer and host port
module i2c_slave_regs #(
   parameter int NREG = 16,
   parameter int PW   = 4
) (
   input logic             clk,
   input logic             reset,
   i2c_slave_regs_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GET_PTR, WRITE, READ} state_t;

   state_t        state, state_next;
   logic [7:0]    regs [NREG];
   logic [PW-1:0] ptr_r, wr_addr_r, ptr_inc;
   logic [7:0]    datasend_r, host_rdata_r;
   logic          wr_pulse_r, received_d, sended_d;
   logic          recv_edge, send_edge;
   logic          do_ptr_load, do_store, do_advance, load_cur, load_next;

   assign recv_edge = bus.received & ~received_d;
   assign send_edge = bus.sended & ~sended_d;
   assign ptr_inc   = ptr_r + PW'(1);

   // GET_PTR doubles as the first-byte flag: entering it on start is what clears it
   always_comb begin
      state_next  = state;
      do_ptr_load = 1'b0;
      do_store    = 1'b0;
      do_advance  = 1'b0;
      load_cur    = 1'b0;
      load_next   = 1'b0;
      if (bus.start) begin
         state_next = GET_PTR;
         load_cur   = 1'b1;
      end else if (bus.stop) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: load_cur = 1'b1;
            GET_PTR: begin
               if (recv_edge) begin
                  do_ptr_load = 1'b1;
                  state_next  = WRITE;
               end else if (send_edge) begin
                  state_next = READ;
                  do_advance = 1'b1;
                  load_next  = 1'b1;
               end
            end
            WRITE: begin
               if (recv_edge) begin
                  do_store   = 1'b1;
                  do_advance = 1'b1;
               end
            end
            READ: begin
               if (send_edge) begin
                  do_advance = 1'b1;
                  load_next  = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
         state        <= IDLE;
         ptr_r        <= '0;
         wr_addr_r    <= '0;
         datasend_r   <= 8'h00;
         host_rdata_r <= 8'h00;
         wr_pulse_r   <= 1'b0;
         received_d   <= 1'b0;
         sended_d     <= 1'b0;
      end else begin
         state        <= state_next;
         received_d   <= bus.received;
         sended_d     <= bus.sended;
         wr_pulse_r   <= do_store;
         host_rdata_r <= regs[bus.host_addr];
         // I2C store is issued last so it overrides a host write to the same index
         if (bus.host_we) regs[bus.host_addr] <= bus.host_wdata;
         if (do_store) begin
            regs[ptr_r] <= bus.datareceive;
            wr_addr_r   <= ptr_r;
         end
         if (do_ptr_load) ptr_r <= bus.datareceive[PW-1:0];
         else if (do_advance) ptr_r <= ptr_inc;
         if (load_cur) datasend_r <= regs[ptr_r];
         else if (load_next) datasend_r <= regs[ptr_inc];
      end
   end

   assign bus.datasend   = datasend_r;
   assign bus.host_rdata = host_rdata_r;
   assign bus.wr_pulse   = wr_pulse_r;
   assign bus.wr_addr    = wr_addr_r;
   assign bus.ptr        = ptr_r;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - scoreboard bench for i2c_slave_regs against a transaction-level model
module tb_i2c_slave_regs;
   localparam int NREG = 16;
   localparam int PW   = 4;
   localparam int M_IDLE = 0, M_FIRST = 1, M_WR = 2, M_RD = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   i2c_slave_regs_if #(.PW(PW)) bus ();
   i2c_slave_regs #(.NREG(NREG), .PW(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct packed {
      logic [PW-1:0] p;
      logic [7:0]    d;
   } probe_t;

   logic [7:0] model_regs [NREG];
   int         mptr;
   int         mode;
   logic [7:0] md;

   int         wr_q [$];
   logic [7:0] ds_q [$];
   logic [7:0] rd_q [$];
   probe_t     probe_q [$];

   logic rd_req = 1'b0, rd_pend = 1'b0, probe = 1'b0, sended_seen = 1'b0;
   int   n_checks = 0, n_pass = 0;

   function void check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   always @(posedge clk) rd_pend <= rd_req;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.wr_pulse) begin
            check("wr_pulse_expected", int'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) check("wr_addr", int'(bus.wr_addr), wr_q.pop_front());
         end
         if (bus.sended && !sended_seen) begin
            check("send_expected", int'(ds_q.size() > 0), 1);
            if (ds_q.size() > 0) check("datasend_shifted", int'(bus.datasend), int'(ds_q.pop_front()));
         end
         if (rd_pend && rd_q.size() > 0) check("host_rdata", int'(bus.host_rdata), int'(rd_q.pop_front()));
         if (probe && probe_q.size() > 0) begin
            probe_t e;
            e = probe_q.pop_front();
            check("ptr", int'(bus.ptr), int'(e.p));
            check("datasend_probe", int'(bus.datasend), int'(e.d));
         end
      end
      sended_seen = bus.sended;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
      mptr = 0;
      mode = M_IDLE;
      md   = 8'h00;
   endtask

   task automatic i2c_start();
      bus.start = 1'b1;
      mode = M_FIRST;
      md   = model_regs[mptr];
      tick();
      bus.start = 1'b0;
   endtask

   task automatic i2c_stop();
      bus.stop = 1'b1;
      mode = M_IDLE;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic model_recv(input logic [7:0] b);
      if (mode == M_FIRST) begin
         mptr = int'(b) % NREG;
         mode = M_WR;
      end else if (mode == M_WR) begin
         model_regs[mptr] = b;
         wr_q.push_back(mptr);
         mptr = (mptr + 1) % NREG;
      end
   endtask

   task automatic i2c_recv(input logic [7:0] b, input int hold);
      model_recv(b);
      bus.datareceive = b;
      bus.received = 1'b1;
      repeat (hold) tick();
      bus.received = 1'b0;
      tick();
   endtask

   task automatic i2c_recv_host(input logic [7:0] b, input int ha, input logic [7:0] hd);
      model_regs[ha] = hd;
      model_recv(b);
      bus.datareceive = b;
      bus.received = 1'b1;
      bus.host_addr = PW'(ha);
      bus.host_wdata = hd;
      bus.host_we = 1'b1;
      tick();
      bus.host_we = 1'b0;
      bus.received = 1'b0;
      tick();
   endtask

   task automatic i2c_send(input int hold);
      ds_q.push_back(mode == M_IDLE ? model_regs[mptr] : md);
      if (mode == M_FIRST) mode = M_RD;
      if (mode == M_RD) begin
         mptr = (mptr + 1) % NREG;
         md = model_regs[mptr];
      end
      bus.sended = 1'b1;
      repeat (hold) tick();
      bus.sended = 1'b0;
      tick();
   endtask

   task automatic host_write(input int a, input logic [7:0] d);
      model_regs[a] = d;
      bus.host_addr = PW'(a);
      bus.host_wdata = d;
      bus.host_we = 1'b1;
      tick();
      bus.host_we = 1'b0;
   endtask

   task automatic host_read(input int a);
      rd_q.push_back(model_regs[a]);
      bus.host_addr = PW'(a);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic probe_now();
      probe_t e;
      tick();
      e.p = PW'(mptr);
      e.d = (mode == M_IDLE) ? model_regs[mptr] : md;
      probe_q.push_back(e);
      probe = 1'b1;
      tick();
      probe = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.datareceive = 8'h00; bus.received = 1'b0;
      bus.sended = 1'b0; bus.host_addr = '0; bus.host_wdata = 8'h00; bus.host_we = 1'b0;
      reset = 1'b1;
      model_reset();
      repeat (3) tick();
      reset = 1'b0;
      probe_now();
      host_read(0); host_read(15);

      // multi-byte write with auto-increment
      i2c_start(); i2c_recv(8'h03, 1); i2c_recv(8'hA5, 2); i2c_recv(8'h5A, 1); i2c_stop();
      probe_now(); host_read(3); host_read(4);

      // pointer write, repeated start, sequential read
      host_write(7, 8'h11); host_write(8, 8'h22);
      i2c_start(); i2c_recv(8'h07, 1); i2c_start(); i2c_send(1); i2c_send(2);
      probe_now(); i2c_stop(); probe_now();

      // wrap from last register to 0
      i2c_start(); i2c_recv(8'h0F, 1); i2c_recv(8'hEE, 1); i2c_recv(8'h77, 1);
      probe_now(); i2c_stop(); host_read(15); host_read(0);

      // host/I2C collision: same index then different index
      i2c_start(); i2c_recv(8'h02, 1);
      i2c_recv_host(8'hC3, 2, 8'h99);
      i2c_recv_host(8'h4D, 3, 8'h66);
      i2c_stop(); host_read(2); host_read(3); host_read(4);

      // long received level stores once; upper pointer bits ignored
      i2c_start(); i2c_recv(8'hF6, 1); i2c_recv(8'h3C, 10); i2c_stop();
      probe_now(); host_read(6);

      // host write to the byte being shifted must not disturb it
      i2c_start(); i2c_recv(8'h0A, 1); i2c_start();
      host_write(10, 8'hBE);
      i2c_send(1); i2c_stop(); i2c_start(); probe_now(); i2c_stop();

      // start+stop together, start+received together
      bus.start = 1'b1; bus.stop = 1'b1; mode = M_FIRST; md = model_regs[mptr];
      tick(); bus.start = 1'b0; bus.stop = 1'b0;
      probe_now();
      bus.datareceive = 8'h0C; bus.received = 1'b1; bus.start = 1'b1;
      mode = M_FIRST; md = model_regs[mptr];
      tick(); bus.start = 1'b0; tick(); bus.received = 1'b0; tick();
      i2c_recv(8'h05, 1); i2c_recv(8'h81, 1); i2c_stop(); probe_now(); host_read(5);

      // randomized transactions
      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(0, 5))
            0: begin
               i2c_start(); i2c_recv(8'($urandom_range(0, 255)), 1);
               repeat ($urandom_range(1, 4)) i2c_recv(8'($urandom_range(0, 255)), $urandom_range(1, 3));
               i2c_stop();
            end
            1: begin
               i2c_start(); i2c_recv(8'($urandom_range(0, 255)), 1); i2c_start();
               repeat ($urandom_range(1, 4)) i2c_send($urandom_range(1, 3));
               i2c_stop();
            end
            2: begin
               i2c_start();
               repeat ($urandom_range(1, 3)) i2c_send($urandom_range(1, 2));
               i2c_stop();
            end
            3: host_write($urandom_range(0, NREG - 1), 8'($urandom_range(0, 255)));
            4: host_read($urandom_range(0, NREG - 1));
            default: begin
               i2c_recv(8'($urandom_range(0, 255)), 1);
               probe_now();
            end
         endcase
      end
      probe_now();

      // received held high across reset must not yield an edge
      reset = 1'b1; bus.datareceive = 8'h09; bus.received = 1'b1;
      tick(); tick(); reset = 1'b0; model_reset(); tick();
      i2c_start(); tick(); probe_now();
      bus.received = 1'b0; tick(); i2c_stop();

      // reset aborting a store in the same cycle
      host_write(5, 8'h42);
      i2c_start(); i2c_recv(8'h05, 1);
      bus.datareceive = 8'hAB; bus.received = 1'b1; reset = 1'b1;
      tick(); reset = 1'b0; model_reset(); bus.received = 1'b0; tick();
      host_read(5);

      // reset during READ
      host_write(1, 8'h5C); host_write(2, 8'hD7);
      i2c_start(); i2c_recv(8'h01, 1); i2c_start(); i2c_send(1);
      do_reset();
      probe_now();
      for (int i = 0; i < NREG; i++) host_read(i);

      repeat (4) tick();
      check("wr_q_drained", wr_q.size(), 0);
      check("ds_q_drained", ds_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      check("probe_q_drained", probe_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter NREG, default 16, meaning the number of 8-bit registers (power of two, 2..256).
REQ-002 The block SHALL have parameter PW, default 4, meaning the pointer width, equal to log2(NREG).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle pulse marking an I2C START or repeated START addressed to this slave.
REQ-006 The block SHALL have port stop, input, 1 bit: one-cycle pulse marking an I2C STOP.
REQ-007 The block SHALL have port datareceive, input, 8 bits: the byte received from the slave PHY.
REQ-008 The block SHALL have port received, input, 1 bit: level, high while datareceive holds a new byte.
REQ-009 The block SHALL have port datasend, output, 8 bits: the byte the slave PHY transmits next.
REQ-010 The block SHALL have port sended, input, 1 bit: level, high after the PHY has shifted out datasend.
REQ-011 The block SHALL have port host_addr, input, PW bits: local register index.
REQ-012 The block SHALL have port host_wdata, input, 8 bits: local write data.
REQ-013 The block SHALL have port host_we, input, 1 bit: local write strobe.
REQ-014 The block SHALL have port host_rdata, output, 8 bits: registered local read data, regs[host_addr], with 1-cycle latency.
REQ-015 The block SHALL have port wr_pulse, output, 1 bit: one-cycle pulse after each I2C data byte is stored.
REQ-016 The block SHALL have port wr_addr, output, PW bits: index written by the last I2C data byte.
REQ-017 The block SHALL have port ptr, output, PW bits: the current register pointer.

Function
REQ-018 received and sended SHALL be rising-edge detected internally (registered previous value), so that each byte is processed exactly once regardless of level duration.
REQ-019 The FSM SHALL have states IDLE, GET_PTR, WRITE and READ.
REQ-020 On start the FSM SHALL go to GET_PTR, load datasend <= regs[ptr], and clear the first-byte flag.
REQ-021 In GET_PTR, a received edge SHALL set ptr <= datareceive[PW-1:0], ignore the upper bits, and move the FSM to WRITE.
REQ-022 In GET_PTR, a sended edge (read directly after START) SHALL move the FSM to READ and apply the READ rule.
REQ-023 In WRITE, a received edge SHALL store regs[ptr] <= datareceive, set wr_addr <= ptr, pulse wr_pulse the next cycle, and set ptr <= ptr+1 modulo NREG.
REQ-024 In READ, a sended edge SHALL set ptr <= ptr+1 modulo NREG and load datasend <= regs[ptr+1] in the same cycle.
REQ-025 datasend SHALL change only on start, on a sended edge, or in IDLE; it SHALL remain stable while a byte is being shifted.
REQ-026 A repeated START SHALL keep ptr unchanged, so that write-pointer-then-restart-read returns regs[ptr].
REQ-027 stop SHALL return the FSM to IDLE and keep ptr and registers unchanged.
REQ-028 In IDLE, received and sended edges SHALL be ignored, and datasend SHALL track regs[ptr].
REQ-029 Pointer wrap SHALL be NREG-1 -> 0 with no flag.
REQ-030 On a simultaneous host_we and I2C store to the same index, the I2C store SHALL win; to different indices, both SHALL complete in the same cycle.
REQ-031 A host write to regs[ptr] during READ SHALL NOT alter the byte being shifted; it SHALL become visible at the next datasend load.
REQ-032 A simultaneous start and stop SHALL be resolved with start taking priority.
REQ-033 A simultaneous start and received edge SHALL be resolved with start taking priority and the byte dropped.

Reset
REQ-034 On reset, the block SHALL set every register to 0x00, ptr=0, FSM=IDLE, datasend=0x00, host_rdata=0x00, wr_pulse=0, wr_addr=0, and both edge-detect registers=0.
REQ-035 Reset mid-transaction SHALL abort it within 1 cycle, with no register write.
REQ-036 After reset, received or sended held high SHALL NOT produce an edge until they go low and high again.

Verification
REQ-037 start, received 0x03, received 0xA5, received 0x5A, stop -> regs[3]=0xA5, regs[4]=0x5A, two wr_pulse with wr_addr 3 then 4, ptr=5.
REQ-038 host writes regs[7]=0x11 and regs[8]=0x22; start, received 0x07, start, sended, sended -> datasend 0x11, then 0x22, then regs[9]; ptr=9.
REQ-039 start, received 0x0F, received 0xEE, received 0x77 -> regs[15]=0xEE, regs[0]=0x77, ptr=1 (wrap).
REQ-040 host_we to index 2 in the same cycle as an I2C store to index 2 -> regs[2] holds the I2C byte; a host write to index 3 in the same cycle -> regs[3] holds the host byte.
REQ-041 received held high for 10 cycles in WRITE -> exactly one store and one wr_pulse.
REQ-042 reset asserted during READ -> next cycle all outputs at reset values; subsequent host_rdata for every index reads 0x00.
